mem_frame_arbiter: RTL and testbench

Frame-granular round-robin arbiter sharing one memory bank write port among three ingress requesters (ports 1..3). It grants a requester for a whole frame, from start-of-frame to end-of-frame, and moves no words while the bank asserts full. A watchdog closes frames whose source stalls, and the block discards orphan words. Sits between the per-port ingress FIFOs and the bank write interface; replaces fixed TDM slot polling.

---
 rtl/mem_frame_arbiter_if.sv | 49 ++++
 rtl/mem_frame_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_mem_frame_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_frame_arbiter_if.sv
// Bus bundle between the three ingress FIFOs, the frame arbiter and the
// memory bank write port.
interface mem_frame_arbiter_if #(
    parameter int unsigned pPORT_WIDTH = 4,
    parameter int unsigned pDATA_W     = 32
);
    localparam int unsigned PortNumW = $clog2(pPORT_WIDTH);

    // Ingress side: bit0 = port 1, bit2 = port 3
    logic [2:0]          i_valid;
    logic [2:0]          o_ready;
    logic [pDATA_W-1:0]  i_data_port1;
    logic [pDATA_W-1:0]  i_data_port2;
    logic [pDATA_W-1:0]  i_data_port3;
    logic [1:0]          i_info_port1;
    logic [1:0]          i_info_port2;
    logic [1:0]          i_info_port3;
    logic [1:0]          i_extra_byte1;
    logic [1:0]          i_extra_byte2;
    logic [1:0]          i_extra_byte3;

    // Bank side
    logic                i_mem_full;
    logic [pDATA_W-1:0]  o_data;
    logic [PortNumW-1:0] o_port_num;
    logic                o_en_mem;
    logic [1:0]          o_info_port;
    logic [1:0]          o_extra_byte;
    logic                o_abort;
    logic [2:0]          o_drop;

    // Drives the ingress words and bank status; observes the arbiter
    modport master (
        output i_valid, i_data_port1, i_data_port2, i_data_port3,
        output i_info_port1, i_info_port2, i_info_port3,
        output i_extra_byte1, i_extra_byte2, i_extra_byte3, i_mem_full,
        input  o_ready, o_data, o_port_num, o_en_mem, o_info_port,
        input  o_extra_byte, o_abort, o_drop
    );

    // The arbiter itself
    modport slave (
        input  i_valid, i_data_port1, i_data_port2, i_data_port3,
        input  i_info_port1, i_info_port2, i_info_port3,
        input  i_extra_byte1, i_extra_byte2, i_extra_byte3, i_mem_full,
        output o_ready, o_data, o_port_num, o_en_mem, o_info_port,
        output o_extra_byte, o_abort, o_drop
    );
endinterface

// File: rtl/mem_frame_arbiter.sv
// Frame-granular round-robin arbiter: one of three ingress ports owns the bank
// write port from SOF to EOF. A watchdog force-closes stalled frames with an
// aborted EOF, and orphan (non-SOF) words seen while idle are discarded.
module mem_frame_arbiter #(
    parameter int unsigned pPORT_WIDTH = 4,
    parameter int unsigned pDATA_W     = 32,
    parameter int unsigned pTIMEOUT    = 64
) (
    input logic                i_clk,
    input logic                i_reset,
    mem_frame_arbiter_if.slave bus
);
    localparam int unsigned PortNumW   = $clog2(pPORT_WIDTH);
    localparam logic [1:0]  InfoEof    = 2'b10;
    localparam logic [1:0]  InfoSof    = 2'b01;
    localparam logic [7:0]  TimeoutVal = 8'(pTIMEOUT);

    typedef enum logic [1:0] {StIdle, StGrant, StAbort} state_e;

    state_e              state_q, state_d;
    logic [1:0]          last_q, last_d;   // last granted port, 0-based
    logic [1:0]          gnt_q, gnt_d;     // port owning the current frame
    logic [7:0]          wdog_q, wdog_d;
    logic [2:0]          disc_q, disc_d;

    logic [pDATA_W-1:0]  data_arr  [3];
    logic [1:0]          info_arr  [3];
    logic [1:0]          extra_arr [3];
    logic [2:0]          valid, sof, cand;
    logic [2:0]          search_idx;
    logic                found;
    logic [1:0]          win;
    logic [2:0]          ready, drop;
    logic                wr, wr_abort;
    logic [1:0]          wr_sel;

    logic [pDATA_W-1:0]  data_q;
    logic [PortNumW-1:0] port_q;
    logic                en_q, abort_q;
    logic [1:0]          info_q, extra_q;
    logic [2:0]          drop_q;

    assign valid        = bus.i_valid;
    assign data_arr[0]  = bus.i_data_port1;
    assign data_arr[1]  = bus.i_data_port2;
    assign data_arr[2]  = bus.i_data_port3;
    assign info_arr[0]  = bus.i_info_port1;
    assign info_arr[1]  = bus.i_info_port2;
    assign info_arr[2]  = bus.i_info_port3;
    assign extra_arr[0] = bus.i_extra_byte1;
    assign extra_arr[1] = bus.i_extra_byte2;
    assign extra_arr[2] = bus.i_extra_byte3;

    // SOF-class heads (01/11) and the ports eligible to open a frame
    always_comb begin
        for (int n = 0; n < 3; n++) begin
            sof[n]  = info_arr[n][0];
            cand[n] = valid[n] & sof[n] & ~disc_q[n];
        end
    end

    // Round-robin search starting just after the last granted port
    always_comb begin
        found      = 1'b0;
        win        = last_q;
        search_idx = 3'd0;
        for (int k = 1; k <= 3; k++) begin
            search_idx = {1'b0, last_q} + 3'(k);
            if (search_idx >= 3'd3) begin
                search_idx = search_idx - 3'd3;
            end
            if (!found && cand[search_idx[1:0]]) begin
                found = 1'b1;
                win   = search_idx[1:0];
            end
        end
    end

    // Next-state, pop strobes and bank write selection
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        wdog_d   = wdog_q;
        disc_d   = disc_q;
        ready    = '0;
        drop     = '0;
        wr       = 1'b0;
        wr_abort = 1'b0;
        wr_sel   = gnt_q;

        // A fresh SOF ends a port's discard episode; it competes next cycle
        for (int n = 0; n < 3; n++) begin
            if (valid[n] && sof[n]) begin
                disc_d[n] = 1'b0;
            end
        end

        unique case (state_q)
            StIdle: begin
                // Orphan words are flushed regardless of bank fullness
                for (int n = 0; n < 3; n++) begin
                    if (valid[n] && !sof[n]) begin
                        ready[n] = 1'b1;
                        drop[n]  = 1'b1;
                    end
                end
                if (found && !bus.i_mem_full) begin
                    ready[win] = 1'b1;
                    wr         = 1'b1;
                    wr_sel     = win;
                    last_d     = win;
                    wdog_d     = 8'd0;
                    if (info_arr[win] == InfoSof) begin
                        state_d = StGrant;
                        gnt_d   = win;
                    end
                end
            end
            StGrant: begin
                if (valid[gnt_q] && sof[gnt_q]) begin
                    // New frame start inside a frame: close it as aborted
                    state_d = StAbort;
                end else if (valid[gnt_q]) begin
                    if (!bus.i_mem_full) begin
                        ready[gnt_q] = 1'b1;
                        wr           = 1'b1;
                        wr_sel       = gnt_q;
                        wdog_d       = 8'd0;
                        if (info_arr[gnt_q] == InfoEof) begin
                            state_d = StIdle;
                        end
                    end
                end else if (!bus.i_mem_full) begin
                    wdog_d = wdog_q + 8'd1;
                    if (wdog_d >= TimeoutVal) begin
                        state_d = StAbort;
                    end
                end
            end
            StAbort: begin
                if (!bus.i_mem_full) begin
                    wr            = 1'b1;
                    wr_abort      = 1'b1;
                    wr_sel        = gnt_q;
                    wdog_d        = 8'd0;
                    disc_d[gnt_q] = 1'b1;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (i_reset) begin
            ready = '0;
        end
    end

    // Arbitration state registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StIdle;
            last_q  <= 2'd2;
            gnt_q   <= 2'd0;
            wdog_q  <= 8'd0;
            disc_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            wdog_q  <= wdog_d;
            disc_q  <= disc_d;
        end
    end

    // Registered bank write and drop pulses
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            data_q  <= '0;
            port_q  <= '0;
            en_q    <= 1'b0;
            info_q  <= 2'b00;
            extra_q <= 2'b00;
            abort_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            en_q    <= wr;
            abort_q <= wr_abort;
            drop_q  <= drop;
            if (wr) begin
                port_q  <= PortNumW'(wr_sel) + PortNumW'(1);
                data_q  <= wr_abort ? '0 : data_arr[wr_sel];
                info_q  <= wr_abort ? InfoEof : info_arr[wr_sel];
                extra_q <= wr_abort ? 2'b00 : extra_arr[wr_sel];
            end
        end
    end

    assign bus.o_ready      = ready;
    assign bus.o_data       = data_q;
    assign bus.o_port_num   = port_q;
    assign bus.o_en_mem     = en_q;
    assign bus.o_info_port  = info_q;
    assign bus.o_extra_byte = extra_q;
    assign bus.o_abort      = abort_q;
    assign bus.o_drop       = drop_q;
endmodule

// File: tb/tb_mem_frame_arbiter.sv
// Scoreboard bench for mem_frame_arbiter: ingress FIFOs are modelled as
// queues, expected bank writes are queued when words are pushed.
module tb_mem_frame_arbiter;
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  info;
        logic [1:0]  extra;
    } word_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  port;
        logic [1:0]  info;
        logic [1:0]  extra;
        logic        abort;
    } wr_t;

    logic i_clk;
    logic i_reset;

    mem_frame_arbiter_if #(.pPORT_WIDTH(4), .pDATA_W(32)) bus ();

    mem_frame_arbiter #(
        .pPORT_WIDTH(4),
        .pDATA_W    (32),
        .pTIMEOUT   (8)
    ) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .bus    (bus)
    );

    int         checks;
    int         errors;
    int         cyc;
    int         fire_at;
    int         drop_cnt [3];
    int         wlog [$];
    logic [2:0] last_fire;
    logic [2:0] last_ready;
    logic [2:0] gate;
    word_t      src [3][$];
    wr_t        exp_q [$];

    always #5 i_clk = ~i_clk;

    // Monitor: every bank write must match the head of the scoreboard
    always @(negedge i_clk) begin
        wr_t e;
        for (int n = 0; n < 3; n++) drop_cnt[n] += int'(bus.o_drop[n]);
        if (bus.o_en_mem === 1'b1) begin
            wlog.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got port %0d info %b data %h abort %b, required none",
                         bus.o_port_num, bus.o_info_port, bus.o_data, bus.o_abort);
            end else begin
                e = exp_q.pop_front();
                if ({bus.o_data, bus.o_port_num, bus.o_info_port, bus.o_extra_byte, bus.o_abort}
                    !== e) begin
                    errors++;
                    $display("FAIL write: got data %h port %0d info %b extra %0d abort %b, required data %h port %0d info %b extra %0d abort %b",
                             bus.o_data, bus.o_port_num, bus.o_info_port, bus.o_extra_byte,
                             bus.o_abort, e.data, e.port, e.info, e.extra, e.abort);
                end
            end
        end
    end

    task automatic drive();
        logic [2:0] v;
        word_t      h [3];
        for (int n = 0; n < 3; n++) begin
            v[n] = gate[n] && (src[n].size() > 0);
            h[n] = (src[n].size() > 0) ? src[n][0] : '0;
        end
        bus.i_valid       = v;
        bus.i_data_port1  = h[0].data;
        bus.i_data_port2  = h[1].data;
        bus.i_data_port3  = h[2].data;
        bus.i_info_port1  = h[0].info;
        bus.i_info_port2  = h[1].info;
        bus.i_info_port3  = h[2].info;
        bus.i_extra_byte1 = h[0].extra;
        bus.i_extra_byte2 = h[1].extra;
        bus.i_extra_byte3 = h[2].extra;
    endtask

    // One clock: sample handshake at negedge, pop and redrive after posedge
    task automatic cycle();
        logic [2:0] f;
        @(negedge i_clk);
        f          = bus.i_valid & bus.o_ready;
        last_fire  = f;
        last_ready = bus.o_ready;
        fire_at    = cyc;
        @(posedge i_clk);
        #1;
        cyc++;
        for (int n = 0; n < 3; n++) begin
            if (f[n]) void'(src[n].pop_front());
        end
        drive();
    endtask

    task automatic push_word(input int p, input logic [1:0] info, input bit expect_wr);
        word_t w;
        wr_t   e;
        w.data  = $urandom;
        w.info  = info;
        w.extra = 2'($urandom_range(0, 3));
        src[p].push_back(w);
        if (expect_wr) begin
            e.data  = w.data;
            e.port  = 2'(p + 1);
            e.info  = info;
            e.extra = w.extra;
            e.abort = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic run_until_empty(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) cycle();
        cycle();
    endtask

    task automatic test_reset();
        cycle();
        cycle();
        checks++;
        if (bus.o_en_mem !== 1'b0 || bus.o_abort !== 1'b0) begin
            errors++;
            $display("FAIL reset_en_abort: got en %b abort %b, required 0 0",
                     bus.o_en_mem, bus.o_abort);
        end
        checks++;
        if (bus.o_data !== 32'h0 || bus.o_port_num !== 2'd0) begin
            errors++;
            $display("FAIL reset_data_port: got %h %0d, required 0 0", bus.o_data, bus.o_port_num);
        end
        checks++;
        if (bus.o_info_port !== 2'b00 || bus.o_extra_byte !== 2'b00 || bus.o_drop !== 3'b000) begin
            errors++;
            $display("FAIL reset_info_extra_drop: got %b %b %b, required 00 00 000",
                     bus.o_info_port, bus.o_extra_byte, bus.o_drop);
        end
        checks++;
        if (last_ready !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 000", last_ready);
        end
        i_reset = 1'b0;
        cycle();
    endtask

    task automatic test_single_word();
        wlog.delete();
        push_word(0, 2'b11, 1'b1);
        push_word(2, 2'b11, 1'b1);
        drive();
        run_until_empty(20);
        checks++;
        if (exp_q.size() !== 0 || wlog.size() !== 2) begin
            errors++;
            $display("FAIL single_word_count: got %0d writes %0d pending, required 2 writes 0 pending",
                     wlog.size(), exp_q.size());
        end else begin
            checks++;
            if (wlog[1] !== wlog[0] + 1) begin
                errors++;
                $display("FAIL single_word_b2b: got cycles %0d %0d, required consecutive",
                         wlog[0], wlog[1]);
            end
        end
    endtask

    task automatic test_round_robin();
        i_reset = 1'b1;
        cycle();
        i_reset = 1'b0;
        wlog.delete();
        for (int p = 0; p < 3; p++) begin
            push_word(p, 2'b01, 1'b1);
            push_word(p, 2'b10, 1'b1);
        end
        drive();
        run_until_empty(40);
        checks++;
        if (exp_q.size() !== 0 || wlog.size() !== 6) begin
            errors++;
            $display("FAIL rr_count: got %0d writes %0d pending, required 6 writes 0 pending",
                     wlog.size(), exp_q.size());
        end else begin
            checks++;
            if (wlog[5] !== wlog[0] + 5) begin
                errors++;
                $display("FAIL rr_no_gap: got span %0d, required 5", wlog[5] - wlog[0]);
            end
        end
    endtask

    task automatic test_single_frame();
        int t_first;
        t_first = -1;
        wlog.delete();
        push_word(1, 2'b01, 1'b1);
        push_word(1, 2'b00, 1'b1);
        push_word(1, 2'b00, 1'b1);
        push_word(1, 2'b10, 1'b1);
        drive();
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) begin
            cycle();
            if (t_first < 0 && last_fire[1]) t_first = fire_at;
        end
        cycle();
        checks++;
        if (exp_q.size() !== 0 || wlog.size() !== 4) begin
            errors++;
            $display("FAIL frame_count: got %0d writes %0d pending, required 4 writes 0 pending",
                     wlog.size(), exp_q.size());
        end else begin
            checks++;
            if (wlog[0] !== t_first + 1 || wlog[3] !== wlog[0] + 3) begin
                errors++;
                $display("FAIL frame_timing: got first %0d last %0d, required first %0d last %0d",
                         wlog[0], wlog[3], t_first + 1, t_first + 4);
            end
        end
    endtask

    task automatic test_backpressure();
        int k;
        int bad;
        bad = 0;
        wlog.delete();
        push_word(0, 2'b01, 1'b1);
        for (int i = 0; i < 4; i++) push_word(0, 2'b00, 1'b1);
        push_word(0, 2'b10, 1'b1);
        drive();
        cycle();
        cycle();
        k = cyc;
        bus.i_mem_full = 1'b1;
        drive();
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (last_ready !== 3'b000) begin
                errors++;
                $display("FAIL bp_ready: got %b, required 000", last_ready);
            end
        end
        // Source also stalls while full, then stalls alone below the timeout
        gate[0] = 1'b0;
        drive();
        for (int i = 0; i < 4; i++) cycle();
        bus.i_mem_full = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        gate[0] = 1'b1;
        drive();
        run_until_empty(30);
        foreach (wlog[i]) begin
            if (wlog[i] > k && wlog[i] <= k + 15) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bp_no_write: got %0d writes during stall, required 0", bad);
        end
        checks++;
        if (exp_q.size() !== 0 || wlog.size() !== 6) begin
            errors++;
            $display("FAIL bp_count: got %0d writes %0d pending, required 6 writes 0 pending",
                     wlog.size(), exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int  t_last;
        wr_t e;
        t_last = -1;
        wlog.delete();
        push_word(2, 2'b01, 1'b1);
        push_word(2, 2'b00, 1'b1);
        drive();
        for (int i = 0; i < 20 && src[2].size() > 0; i++) begin
            cycle();
            if (last_fire[2]) t_last = fire_at;
        end
        e.data  = 32'h0;
        e.port  = 2'd3;
        e.info  = 2'b10;
        e.extra = 2'b00;
        e.abort = 1'b1;
        exp_q.push_back(e);
        run_until_empty(30);
        checks++;
        if (exp_q.size() !== 0 || wlog.size() !== 3) begin
            errors++;
            $display("FAIL timeout_count: got %0d writes %0d pending, required 3 writes 0 pending",
                     wlog.size(), exp_q.size());
        end else begin
            checks++;
            if (wlog[2] !== t_last + 10) begin
                errors++;
                $display("FAIL timeout_cycle: got abort at %0d, required %0d",
                         wlog[2], t_last + 10);
            end
        end
        for (int n = 0; n < 3; n++) drop_cnt[n] = 0;
        push_word(2, 2'b00, 1'b0);
        push_word(2, 2'b10, 1'b0);
        push_word(2, 2'b01, 1'b1);
        push_word(2, 2'b10, 1'b1);
        drive();
        run_until_empty(30);
        cycle();
        checks++;
        if (drop_cnt[2] !== 2 || drop_cnt[0] !== 0 || drop_cnt[1] !== 0) begin
            errors++;
            $display("FAIL timeout_drops: got %0d %0d %0d, required 0 0 2",
                     drop_cnt[0], drop_cnt[1], drop_cnt[2]);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL timeout_next_frame: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        wlog.delete();
        push_word(0, 2'b01, 1'b0);
        push_word(0, 2'b00, 1'b0);
        push_word(0, 2'b00, 1'b0);
        push_word(0, 2'b10, 1'b0);
        drive();
        cycle();
        i_reset = 1'b1;
        src[0].delete();
        push_word(0, 2'b01, 1'b1);
        push_word(0, 2'b10, 1'b1);
        push_word(1, 2'b01, 1'b1);
        push_word(1, 2'b10, 1'b1);
        drive();
        cycle();
        checks++;
        if ({bus.o_en_mem, bus.o_data, bus.o_port_num, bus.o_info_port, bus.o_extra_byte,
             bus.o_abort, bus.o_drop} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got en %b data %h port %0d info %b, required all 0",
                     bus.o_en_mem, bus.o_data, bus.o_port_num, bus.o_info_port);
        end
        checks++;
        if (last_ready !== 3'b000) begin
            errors++;
            $display("FAIL midreset_ready: got %b, required 000", last_ready);
        end
        i_reset = 1'b0;
        run_until_empty(30);
        checks++;
        if (exp_q.size() !== 0 || wlog.size() !== 4) begin
            errors++;
            $display("FAIL midreset_after: got %0d writes %0d pending, required 4 writes 0 pending",
                     wlog.size(), exp_q.size());
        end
    endtask

    initial begin
        i_clk          = 1'b0;
        i_reset        = 1'b1;
        checks         = 0;
        errors         = 0;
        cyc            = 0;
        gate           = 3'b111;
        bus.i_mem_full = 1'b0;
        for (int n = 0; n < 3; n++) drop_cnt[n] = 0;
        drive();

        test_reset();
        test_single_word();
        test_round_robin();
        test_single_frame();
        test_backpressure();
        test_timeout();
        test_reset_mid_frame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
